// File: rtl/dct_stream_pkg.sv
// Shared definitions for the DCT stream adapter: EOB code, FSM states and
// the per-beat EOB counting helper.
package dct_stream_pkg;

  // Upper bounds on the lane count and coefficient width
  localparam int MAX_LANES  = 8;
  localparam int MAX_COEF_W = 64;

  // End-of-block code: all ones, sliced down to the coefficient width
  localparam logic [MAX_COEF_W-1:0] EOB_CODE = '1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Count how many lanes of a beat carry the EOB code (0..MAX_LANES)
  function automatic logic [3:0] eob_count(input logic [MAX_LANES-1:0] hits);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      cnt = cnt + {3'b000, hits[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dct_stream_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is dropped,
// even when a pop happens in the same cycle.
module dct_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = push && (r_count != C_DEPTH);
  assign w_pop_ok  = pop && (r_count != '0);

  // Storage write
  // NOTE: the data array has no reset; only pointers and count are reset, so
  // stale entries are never visible and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = (r_count == C_DEPTH);
  assign empty   = (r_count == '0);
  assign free    = C_DEPTH - r_count;

endmodule

// File: rtl/dct_stream_adapter.sv
// AXI-Stream shell around a fixed-latency, non-stallable DCT/run-length core.
// Tracks blocks in/out, carries frame boundaries from s_axis_tlast to
// m_axis_tlast by counting EOB codes, and flags protocol errors.
module dct_stream_adapter
  import dct_stream_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int PIX_W      = 8,
  parameter int COEF_W     = 16,
  parameter int BLOCK_PIX  = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int SLACK      = 16,
  parameter int CNT_W      = 26
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [LANES*PIX_W-1:0]    s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic [LANES*COEF_W-1:0]   m_axis_tdata,
  output logic [LANES*COEF_W/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [LANES*PIX_W-1:0]    core_wdata,
  output logic                      core_wen,
  input  logic [LANES*COEF_W-1:0]   core_rdata,
  input  logic                      core_rvalid,
  output logic [CNT_W-1:0]          blocks_in,
  output logic [CNT_W-1:0]          blocks_out,
  output logic                      err_overflow,
  output logic                      err_misaligned
);

  localparam int OUT_W  = LANES*COEF_W;
  localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PIX_CW = (BLOCK_PIX > 1) ? $clog2(BLOCK_PIX) : 1;
  localparam logic [PIX_CW:0]   C_BLOCK = (PIX_CW+1)'(BLOCK_PIX);
  localparam logic [PIX_CW:0]   C_LANES = (PIX_CW+1)'(LANES);
  localparam logic [FREE_W-1:0] C_SLACK = FREE_W'(SLACK);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_s_tready;
  logic [LANES*PIX_W-1:0] r_core_wdata;
  logic                  r_core_wen;
  logic [PIX_CW-1:0]     r_pix_cnt;
  logic [CNT_W-1:0]      r_blocks_in;
  logic [CNT_W-1:0]      r_blocks_out;
  logic [CNT_W-1:0]      r_frame_blocks;
  logic [CNT_W-1:0]      r_frame_eobs;
  logic                  r_err_overflow;
  logic                  r_err_misaligned;

  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_push;
  logic [PIX_CW:0]       w_pix_sum;
  logic [PIX_CW:0]       w_pix_sub;
  logic                  w_pix_wrap;
  logic [PIX_CW-1:0]     w_pix_next;
  logic [CNT_W-1:0]      w_blocks_in_next;
  logic [CNT_W-1:0]      w_frame_blocks_new;
  logic [OUT_W-1:0]      w_fifo_rdata;
  logic                  w_full;
  logic                  w_empty;
  logic [FREE_W-1:0]     w_free;
  logic [FREE_W-1:0]     w_free_next;
  logic [MAX_LANES-1:0]  w_lane_eob;
  logic [3:0]            w_eob_cnt;
  logic [CNT_W-1:0]      w_eob_ext;
  logic                  w_tlast;

  assign w_in_hs  = s_axis_tvalid && r_s_tready;
  assign w_out_hs = !w_empty && m_axis_tready;
  assign w_push   = core_rvalid && !w_full;

  // Pixel position within the current block; wrap marks a completed block
  assign w_pix_sum  = {1'b0, r_pix_cnt} + C_LANES;
  assign w_pix_wrap = (w_pix_sum >= C_BLOCK);
  assign w_pix_sub  = w_pix_sum - C_BLOCK;
  assign w_pix_next = w_pix_wrap ? w_pix_sub[PIX_CW-1:0] : w_pix_sum[PIX_CW-1:0];
  assign w_blocks_in_next = r_blocks_in + {{(CNT_W-1){1'b0}}, w_pix_wrap};

  // blocks_out minus frame_eobs is the blocks_out value at frame start
  assign w_frame_blocks_new = w_blocks_in_next - (r_blocks_out - r_frame_eobs);

  dct_stream_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (core_rvalid),
    .push_data (core_rdata),
    .pop       (w_out_hs),
    .rd_data   (w_fifo_rdata),
    .full      (w_full),
    .empty     (w_empty),
    .free      (w_free)
  );

  assign w_free_next = w_free + {{(FREE_W-1){1'b0}}, w_out_hs}
                              - {{(FREE_W-1){1'b0}}, w_push};

  // Flag every lane of the FIFO head that carries the EOB code
  // NOTE: combinational outputs get a default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_lane_eob = '0;
    for (int l = 0; l < LANES; l++) begin
      w_lane_eob[l] = (w_fifo_rdata[l*COEF_W +: COEF_W] == EOB_CODE[COEF_W-1:0]);
    end
  end

  assign w_eob_cnt = eob_count(w_lane_eob);
  assign w_eob_ext = {{(CNT_W-4){1'b0}}, w_eob_cnt};

  // The head beat closes the frame once its EOBs reach the latched block count
  assign w_tlast = (r_state == ST_DRAIN) && !w_empty && (w_eob_cnt != 4'd0) &&
                   ((r_frame_eobs + w_eob_ext) >= r_frame_blocks);

  // Frame state transitions: one open frame at a time
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_in_hs && s_axis_tlast && (w_frame_blocks_new != '0)) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_out_hs && w_tlast) w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // FSM, counters, core write port and sticky error flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state          <= ST_RUN;
      r_s_tready       <= 1'b0;
      r_core_wdata     <= '0;
      r_core_wen       <= 1'b0;
      r_pix_cnt        <= '0;
      r_blocks_in      <= '0;
      r_blocks_out     <= '0;
      r_frame_blocks   <= '0;
      r_frame_eobs     <= '0;
      r_err_overflow   <= 1'b0;
      r_err_misaligned <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_s_tready <= (w_state_next == ST_RUN) && (w_free_next > C_SLACK);
      r_core_wen <= w_in_hs;
      if (w_in_hs) begin
        r_core_wdata <= s_axis_tdata;
        r_blocks_in  <= w_blocks_in_next;
        if (s_axis_tlast) begin
          // A partial trailing block is discarded and counting restarts
          r_pix_cnt      <= '0;
          r_frame_blocks <= w_frame_blocks_new;
          if (w_pix_next != '0) r_err_misaligned <= 1'b1;
        end else begin
          r_pix_cnt <= w_pix_next;
        end
      end
      if (core_rvalid && w_full) r_err_overflow <= 1'b1;
      if (w_out_hs) begin
        r_blocks_out <= r_blocks_out + w_eob_ext;
        r_frame_eobs <= (w_tlast) ? '0 : (r_frame_eobs + w_eob_ext);
      end
    end
  end

  assign s_axis_tready  = r_s_tready;
  assign core_wdata     = r_core_wdata;
  assign core_wen       = r_core_wen;
  assign m_axis_tdata   = w_fifo_rdata;
  assign m_axis_tkeep   = '1;
  assign m_axis_tvalid  = !w_empty;
  assign m_axis_tlast   = w_tlast;
  assign blocks_in      = r_blocks_in;
  assign blocks_out     = r_blocks_out;
  assign err_overflow   = r_err_overflow;
  assign err_misaligned = r_err_misaligned;

endmodule

// File: tb/tb_dct_stream_adapter.sv
// Scoreboard bench for dct_stream_adapter: directed input frames, a directed
// core-output model, and a monitor comparing every output beat in order.
module tb_dct_stream_adapter;

  localparam int LANES      = 2;
  localparam int PIX_W      = 8;
  localparam int COEF_W     = 16;
  localparam int BLOCK_PIX  = 64;
  localparam int FIFO_DEPTH = 32;
  localparam int SLACK      = 16;
  localparam int CNT_W      = 26;

  logic                      aclk = 1'b0;
  logic                      aresetn = 1'b0;
  logic [LANES*PIX_W-1:0]    s_axis_tdata = '0;
  logic                      s_axis_tvalid = 1'b0;
  logic                      s_axis_tready;
  logic                      s_axis_tlast = 1'b0;
  logic [LANES*COEF_W-1:0]   m_axis_tdata;
  logic [LANES*COEF_W/8-1:0] m_axis_tkeep;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready = 1'b0;
  logic                      m_axis_tlast;
  logic [LANES*PIX_W-1:0]    core_wdata;
  logic                      core_wen;
  logic [LANES*COEF_W-1:0]   core_rdata = '0;
  logic                      core_rvalid = 1'b0;
  logic [CNT_W-1:0]          blocks_in;
  logic [CNT_W-1:0]          blocks_out;
  logic                      err_overflow;
  logic                      err_misaligned;

  always #5 aclk = ~aclk;

  dct_stream_adapter #(
    .LANES(LANES), .PIX_W(PIX_W), .COEF_W(COEF_W), .BLOCK_PIX(BLOCK_PIX),
    .FIFO_DEPTH(FIFO_DEPTH), .SLACK(SLACK), .CNT_W(CNT_W)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .core_wdata(core_wdata), .core_wen(core_wen),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .blocks_in(blocks_in), .blocks_out(blocks_out),
    .err_overflow(err_overflow), .err_misaligned(err_misaligned)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   n_out     = 0;
  int   sink_mode = 0;  // 0: always ready, 1: ~30% ready, 2: stalled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired before the DUT responded", name);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "aborted");
  endtask

  // Sink ready pattern, updated just after each rising edge
  always @(posedge aclk) begin
    #1;
    case (sink_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 99) < 30);
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Monitor: every output handshake pops one expected beat
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat: got 0x%0h expected no beat", m_axis_tdata);
      end else begin
        e = sb.pop_front();
        check("out_data", m_axis_tdata, e.data);
        check("out_last", {31'd0, m_axis_tlast}, {31'd0, e.last});
      end
    end
  end

  initial begin
    #500000;
    abort("watchdog");
  end

  task automatic send_beat(input logic [15:0] d, input logic l);
    int waited;
    waited = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      waited++;
      if (waited > 500) abort("in_tready_timeout");
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic last_at_end, input int base);
    for (int i = 0; i < n; i++) begin
      send_beat(16'(base + i), last_at_end && (i == n - 1));
    end
  endtask

  task automatic core_beat(input logic [31:0] d, input logic exp_last, input logic kept);
    exp_t e;
    if (kept) begin
      e.data = d;
      e.last = exp_last;
      sb.push_back(e);
    end
    core_rdata  = d;
    core_rvalid = 1'b1;
    @(posedge aclk);
    #1;
    core_rvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 || m_axis_tvalid) begin
      @(negedge aclk);
      n++;
      if (n > 2000) abort("drain_timeout");
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic set_sink(input int mode);
    sink_mode = mode;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int out_base;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst_tready",   {31'd0, s_axis_tready}, 32'd0);
    check("rst_core_wen", {31'd0, core_wen},      32'd0);
    check("rst_wdata",    {16'd0, core_wdata},    32'd0);
    check("rst_mvalid",   {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_mlast",    {31'd0, m_axis_tlast},  32'd0);
    check("rst_blk_in",   32'(blocks_in),         32'd0);
    check("rst_blk_out",  32'(blocks_out),        32'd0);
    check("rst_errs",     {30'd0, err_overflow, err_misaligned}, 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("tready_first_edge", {31'd0, s_axis_tready}, 32'd1);

    // Basic frame: 2 blocks, 3 core beats per block, EOB in lane 1
    send_beat(16'h0100, 1'b0);
    check("core_wen", {31'd0, core_wen}, 32'd1);
    check("core_wdata", {16'd0, core_wdata}, 32'h0100);
    check("tkeep", {28'd0, m_axis_tkeep}, 32'hF);
    send_beats(63, 1'b1, 1);
    check("f1_blocks_in", 32'(blocks_in), 32'd2);
    check("f1_tready_drain", {31'd0, s_axis_tready}, 32'd0);
    core_beat(32'h0022_0011, 1'b0, 1'b1);
    core_beat(32'h0044_0033, 1'b0, 1'b1);
    core_beat(32'hFFFF_0055, 1'b0, 1'b1);
    core_beat(32'h0077_0066, 1'b0, 1'b1);
    core_beat(32'h0099_0088, 1'b0, 1'b1);
    core_beat(32'hFFFF_00AA, 1'b1, 1'b1);
    check("f1_tready_before_last", {31'd0, s_axis_tready}, 32'd0);
    wait_drain();
    check("f1_blocks_out", 32'(blocks_out), 32'd2);
    check("f1_tready_after", {31'd0, s_axis_tready}, 32'd1);

    // Double EOB in one beat closes a 2-block frame
    send_beats(64, 1'b1, 16'h0200);
    check("f2_blocks_in", 32'(blocks_in), 32'd4);
    core_beat(32'h5678_1234, 1'b0, 1'b1);
    core_beat(32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_drain();
    check("f2_blocks_out", 32'(blocks_out), 32'd4);

    // Back-pressure: tready falls when free reaches SLACK, random sink drains
    set_sink(2);
    for (int i = 0; i < 15; i++) core_beat(32'h3000 + i, 1'b0, 1'b1);
    check("bp_tready_free17", {31'd0, s_axis_tready}, 32'd1);
    core_beat(32'h3100, 1'b0, 1'b1);
    check("bp_tready_free16", {31'd0, s_axis_tready}, 32'd0);
    set_sink(1);
    send_beats(32, 1'b1, 16'h0300);
    core_beat(32'h0B0B_0A0A, 1'b0, 1'b1);
    core_beat(32'h0D0D_0C0C, 1'b0, 1'b1);
    core_beat(32'hFFFF_0E0E, 1'b1, 1'b1);
    wait_drain();
    check("bp_no_overflow", {31'd0, err_overflow}, 32'd0);
    check("bp_blocks_in", 32'(blocks_in), 32'd5);
    check("bp_blocks_out", 32'(blocks_out), 32'd5);
    set_sink(0);

    // Misaligned tlast after 80 pixels: one whole block only
    send_beats(40, 1'b1, 16'h0400);
    check("mis_flag", {31'd0, err_misaligned}, 32'd1);
    check("mis_blocks_in", 32'(blocks_in), 32'd6);
    check("mis_tready_drain", {31'd0, s_axis_tready}, 32'd0);
    core_beat(32'h0002_0001, 1'b0, 1'b1);
    core_beat(32'hFFFF_0003, 1'b1, 1'b1);
    wait_drain();
    check("mis_blocks_out", 32'(blocks_out), 32'd6);
    // Pixel count restarted at 0: 24 beats must not complete a block
    send_beats(24, 1'b0, 16'h0500);
    check("mis_pix_restart", 32'(blocks_in), 32'd6);
    send_beats(8, 1'b1, 16'h0600);
    check("mis_next_blocks_in", 32'(blocks_in), 32'd7);
    core_beat(32'hFFFF_0007, 1'b1, 1'b1);
    wait_drain();
    check("mis_next_blocks_out", 32'(blocks_out), 32'd7);

    // Overflow: fill beyond depth with the sink stalled
    set_sink(2);
    for (int i = 0; i < FIFO_DEPTH; i++) core_beat(32'h5000 + i, 1'b0, 1'b1);
    check("ovf_tready_full", {31'd0, s_axis_tready}, 32'd0);
    check("ovf_flag_before", {31'd0, err_overflow}, 32'd0);
    for (int i = 0; i < 3; i++) core_beat(32'h6000 + i, 1'b0, 1'b0);
    check("ovf_flag", {31'd0, err_overflow}, 32'd1);
    out_base = n_out;
    set_sink(0);
    wait_drain();
    check("ovf_out_count", 32'(n_out - out_base), 32'(FIFO_DEPTH));
    check("ovf_blocks_out", 32'(blocks_out), 32'd7);

    // Reset mid-frame, then a fresh 1-block frame
    set_sink(2);
    send_beats(20, 1'b0, 16'h0700);
    core_beat(32'h7777_7777, 1'b0, 1'b0);
    core_beat(32'hFFFF_7778, 1'b0, 1'b0);
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    sb.delete();
    check("mid_rst_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("mid_rst_tready", {31'd0, s_axis_tready}, 32'd0);
    check("mid_rst_counters", 32'(blocks_in) | 32'(blocks_out), 32'd0);
    check("mid_rst_errs", {30'd0, err_overflow, err_misaligned}, 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    set_sink(0);
    send_beats(32, 1'b1, 16'h0800);
    check("post_rst_blocks_in", 32'(blocks_in), 32'd1);
    check("post_rst_aligned", {31'd0, err_misaligned}, 32'd0);
    core_beat(32'h1111_2222, 1'b0, 1'b1);
    core_beat(32'hFFFF_3333, 1'b1, 1'b1);
    wait_drain();
    check("post_rst_blocks_out", 32'(blocks_out), 32'd1);
    check("post_rst_tready", {31'd0, s_axis_tready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dct_stream_adapter.md
# dct_stream_adapter

Parametrised AXI-Stream shell between a DMA-facing pixel stream and a fixed-latency, non-stallable DCT/run-length core. Generalises the two-pixel DCT stream wrapper: lane count and widths are parameters, upstream back-pressure is credit-based, and frame boundaries are carried from `s_axis_tlast` through to `m_axis_tlast`. It also counts end-of-block (EOB) codes per beat and flags protocol errors. It sits between the AXI DMA MM2S/S2MM channels and the core's `wdata`/`rdata` ports.

## Interface
- `LANES`, 2, pixels per input beat and coefficients per output beat (power of two, 1..8)
- `PIX_W`, 8, pixel width
- `COEF_W`, 16, coded output word width (multiple of 8)
- `BLOCK_PIX`, 64, pixels per DCT block (power of two, multiple of `LANES`)
- `FIFO_DEPTH`, 512, output FIFO entries (power of two)
- `SLACK`, 16, worst-case core beats in flight; also the FIFO headroom reserved
- `CNT_W`, 26, width of the block counters
- `aclk` in 1: the single clock
- `aresetn` in 1: asynchronous, active-low reset
- `s_axis_tdata` in `LANES*PIX_W`: lane 0 is in bits [PIX_W-1:0]
- `s_axis_tvalid` in 1, `s_axis_tready` out 1, `s_axis_tlast` in 1: end of frame
- `m_axis_tdata` out `LANES*COEF_W`; `m_axis_tkeep` out `LANES*COEF_W/8`, all ones
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1
- `core_wdata` out `LANES*PIX_W`, `core_wen` out 1: core input
- `core_rdata` in `LANES*COEF_W`, `core_rvalid` in 1: core output (cannot stall)
- `blocks_in`, `blocks_out` out `CNT_W`: running block counters
- `err_overflow` out 1, `err_misaligned` out 1: sticky error flags

## Operation
- **EOB code.** All ones in `COEF_W` bits. `eob_cnt` is the number of lanes in a beat that equal the EOB code (0..`LANES`).
- **Input path.** On an input handshake, register `s_axis_tdata` into `core_wdata` and pulse `core_wen` one cycle later.
- **Pixel counting.** `pix_cnt` advances by `LANES` per handshake and wraps at `BLOCK_PIX`. On the wrap, `blocks_in` increments.
- **Frame capture.** On a handshake with `s_axis_tlast`=1, latch `frame_blocks = blocks_in_after_beat - blocks_out_at_frame_start` and enter DRAIN.
  - If `pix_cnt` after the beat is not 0, set `err_misaligned`.
  - With a misaligned tlast, the partial block is not counted and `pix_cnt` resets to 0.
  - If the resulting `frame_blocks` is 0, stay in RUN.
- **Output path.** Each `core_rvalid` beat is written to the FIFO. If the FIFO is full, drop the beat and set `err_overflow`.
- **Output handshake.** `m_axis_tvalid` = FIFO not empty (FWFT). Each `m_axis_tvalid && m_axis_tready` pops one entry and adds `eob_cnt` to `blocks_out` and to `frame_eobs`.
- **`m_axis_tlast`.** Combinational: asserted when in DRAIN, `eob_cnt` ≠ 0, and `frame_eobs + eob_cnt >= frame_blocks`.
- **State machine.**
  - RUN → DRAIN on an accepted tlast with `frame_blocks` ≠ 0.
  - DRAIN → RUN on the handshake of the tlast beat; this clears `frame_eobs`.
- **`s_axis_tready`.** Registered: next value = (state_next == RUN) && (fifo_free_next > `SLACK`). While in DRAIN, input is held off, so only one frame is ever open.
- **Counters.** All counters wrap modulo 2^`CNT_W`. Comparisons use the difference `blocks_in - blocks_out` so that wrap is harmless.
- **Error flags.** Cleared only by reset.

## Timing
- **Reset.** On asynchronous assertion:
  - `s_axis_tready`, `core_wen`, `m_axis_tvalid`, `m_axis_tlast` go to 0.
  - `core_wdata`, both counters, both error flags and `frame_*` go to 0.
  - The FIFO is emptied and the state returns to RUN.
  - `s_axis_tready` first rises on the first clock edge after `aresetn` deasserts.
  - A reset mid-frame discards all in-flight data.
- **Latency.** Input handshake to `core_wen`: 1 cycle. `core_rvalid` to `m_axis_tvalid` (FIFO empty): 1 cycle.
- **Simultaneous events.** FIFO push and pop in the same cycle leave the occupancy unchanged. A push when full is dropped even if a pop occurs in the same cycle.
- **Back-pressure.** `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` are held stable while `m_axis_tready`=0.
- **Throughput.** One beat per cycle on both sides in RUN with the sink ready.

## Structure
- Package `dct_stream_pkg`:
  - EOB code constant;
  - state enum {RUN, DRAIN};
  - a function computing `eob_cnt` per beat.
- Sub-module `dct_stream_fifo`: synchronous FWFT FIFO, parameters `WIDTH`/`DEPTH`, outputs `full`/`empty`/`free`.
- The core itself is external and is not instantiated here.

## Test plan
- **Basic frame.** LANES=2: 64 beats (2 blocks) with tlast on beat 64; core model returns 3 beats per block, last lane EOB → `blocks_in`=2, `blocks_out`=2, `m_axis_tlast` on output beat 6 only, `s_axis_tready` low from the cycle after input beat 64 until output beat 6 handshakes.
- **Double EOB in one beat.** A beat with both lanes = 0xFFFF → `blocks_out` advances by 2; tlast asserts if this completes the frame.
- **Back-pressure.** Random `m_axis_tready` 30% duty, FIFO_DEPTH=32, SLACK=16 → no `err_overflow`; `s_axis_tready` drops when free ≤ 16; output data order identical to a scoreboard.
- **Misaligned tlast.** tlast on input beat 40 (80 pixels) → `err_misaligned`=1, `frame_blocks`=1, tlast on the first EOB out.
- **Overflow.** Core model pushes with `m_axis_tready`=0 beyond depth → `err_overflow`=1 and exactly DEPTH beats are later output.
- **Reset mid-frame.** Reset mid-frame, then a fresh 1-block frame → all counters restart from 0 and a correct single tlast is produced.
